// File: rtl/gpr_access_arbiter_if.sv
// Bundle of requester-side and GPR-side signals for gpr_access_arbiter.
// slave  : the arbiter's view (samples requests and GPR read data, drives
//          grants, strobes and read data).
// master : the environment's view (requesters plus the GPR itself).
interface gpr_access_arbiter_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12
);
    // Requester a
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              gnt_a;
    logic              rvalid_a;
    // Requester b
    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_b;
    logic              rvalid_b;
    // Shared read data and GPR side
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] gpr_addr;
    logic [DATA_W-1:0] gpr_data_in;
    logic              gpr_rd;
    logic              gpr_wr;
    logic [DATA_W-1:0] gpr_data_out;
    logic              busy;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  gpr_data_out,
        output gnt_a, rvalid_a, gnt_b, rvalid_b,
        output rdata, gpr_addr, gpr_data_in, gpr_rd, gpr_wr, busy
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output gpr_data_out,
        input  gnt_a, rvalid_a, gnt_b, rvalid_b,
        input  rdata, gpr_addr, gpr_data_in, gpr_rd, gpr_wr, busy
    );
endinterface

// File: rtl/gpr_access_arbiter.sv
// Two-requester arbiter in front of a single-port GPR file.
// One access at a time: IDLE latches the winner, ISSUE drives the GPR strobe
// and the grant, RESP (reads only) returns the registered GPR data.
// Optional feature: define GPR_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on contention; otherwise requester a has fixed priority over b.
module gpr_access_arbiter #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12
) (
    input  logic clk,
    input  logic rst_n,
    gpr_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    logic              lat_we;     // latched direction of the access in flight
    logic              lat_b;      // latched winner: 1 = b, 0 = a
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;    // last returned read data, held outside RESP
    logic              win_b;      // arbitration result for the current IDLE edge
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef GPR_ARB_ROUND_ROBIN_EN
    logic last_b;                  // 1 = b won the most recent latch

    // Round-robin: on contention the requester that did not win last is chosen.
    always_comb begin
        win_b = bus.req_b & (~bus.req_a | ~last_b);
    end

    // Pointer moves only when an access is actually latched; resets to "b won
    // last" so that a wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (state == IDLE && (bus.req_a || bus.req_b)) begin
            last_b <= win_b;
        end
    end
`else
    // Fixed priority: a always beats b.
    always_comb begin
        win_b = bus.req_b & ~bus.req_a;
    end
`endif

    // Mux the winner's request fields.
    // NOTE: every output of an always_comb is assigned on every path, so no
    // latch can be inferred here.
    always_comb begin
        win_we    = win_b ? bus.we_b    : bus.we_a;
        win_addr  = win_b ? bus.addr_b  : bus.addr_a;
        win_wdata = win_b ? bus.wdata_b : bus.wdata_a;
    end

    // Access sequencer with registered grant, strobe and rvalid outputs.
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_we       <= 1'b0;
            lat_b        <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            rdata_q      <= '0;
            bus.gnt_a    <= 1'b0;
            bus.gnt_b    <= 1'b0;
            bus.rvalid_a <= 1'b0;
            bus.rvalid_b <= 1'b0;
            bus.gpr_rd   <= 1'b0;
            bus.gpr_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        state      <= ISSUE;
                        lat_we     <= win_we;
                        lat_b      <= win_b;
                        lat_addr   <= win_addr;
                        lat_wdata  <= win_wdata;
                        bus.gnt_a  <= ~win_b;
                        bus.gnt_b  <= win_b;
                        bus.gpr_wr <= win_we;
                        bus.gpr_rd <= ~win_we;
                    end
                end
                ISSUE: begin
                    bus.gnt_a  <= 1'b0;
                    bus.gnt_b  <= 1'b0;
                    bus.gpr_wr <= 1'b0;
                    bus.gpr_rd <= 1'b0;
                    if (lat_we) begin
                        state <= IDLE;
                    end else begin
                        state        <= RESP;
                        bus.rvalid_a <= ~lat_b;
                        bus.rvalid_b <= lat_b;
                    end
                end
                RESP: begin
                    // GPR data is valid during RESP; keep it for the hold period.
                    bus.rvalid_a <= 1'b0;
                    bus.rvalid_b <= 1'b0;
                    rdata_q      <= bus.gpr_data_out;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The GPR returns data one cycle after gpr_rd, so rdata passes it straight
    // through during RESP and shows the held copy otherwise.
    assign bus.rdata       = (state == RESP) ? bus.gpr_data_out : rdata_q;
    assign bus.gpr_addr    = lat_addr;
    assign bus.gpr_data_in = lat_wdata;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_gpr_access_arbiter.sv
// Self-checking bench for gpr_access_arbiter: directed scenarios plus
// randomized traffic, all compared every cycle against a transaction-level
// model of the arbiter and a behavioural GPR file.
module tb_gpr_access_arbiter;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   mon_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    gpr_access_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    gpr_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input int a);
        if (a == 12'h0AA) return 14'h0123;
        return DATA_W'(a * 37 + 5);
    endfunction

    // Behavioural GPR: registered read data, one cycle after gpr_rd.
    logic [DATA_W-1:0] gpr_mem [4096];
    initial begin
        for (int i = 0; i < 4096; i++) gpr_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (bus.gpr_wr) gpr_mem[bus.gpr_addr] <= bus.gpr_data_in;
            if (bus.gpr_rd) bus.gpr_data_out <= gpr_mem[bus.gpr_addr];
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic              ga, gb, wr, rd, busy, rva, rvb;
        logic [DATA_W-1:0] rdata;
    } slot_t;

    slot_t             cur, nxt;          // expected outputs: this cycle, next cycle
    logic [ADDR_W-1:0] e_addr  = '0;
    logic [DATA_W-1:0] e_din   = '0;
    logic [DATA_W-1:0] e_rdata = '0;
    logic [DATA_W-1:0] model_mem [4096];
    int                cyc = 0, next_arb = 0;
    bit                last_a = 1'b0;     // 0 = b won last (reset value)

    initial begin
        bit                mw_b, mwe;
        logic [ADDR_W-1:0] maddr;
        cur = '0;
        nxt = '0;
        for (int i = 0; i < 4096; i++) model_mem[i] = init_val(i);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cur = '0; nxt = '0;
                e_addr = '0; e_din = '0; e_rdata = '0;
                cyc = 0; next_arb = 0; last_a = 1'b0;
            end else begin
                if (cur.wr) model_mem[e_addr] = e_din;   // write lands at this edge
                cur = nxt;
                nxt = '0;
                if (cur.rva || cur.rvb) e_rdata = cur.rdata;
                cyc++;
                if ((bus.req_a || bus.req_b) && cyc >= next_arb) begin
`ifdef GPR_ARB_ROUND_ROBIN_EN
                    mw_b = (bus.req_a && bus.req_b) ? last_a : bus.req_b;
`else
                    mw_b = !bus.req_a;
`endif
                    mwe    = mw_b ? bus.we_b : bus.we_a;
                    maddr  = mw_b ? bus.addr_b : bus.addr_a;
                    e_addr = maddr;
                    e_din  = mw_b ? bus.wdata_b : bus.wdata_a;
                    cur.ga = !mw_b; cur.gb = mw_b;
                    cur.wr = mwe;   cur.rd = !mwe;
                    cur.busy = 1'b1;
                    if (!mwe) begin
                        nxt.busy  = 1'b1;
                        nxt.rva   = !mw_b;
                        nxt.rvb   = mw_b;
                        nxt.rdata = model_mem[maddr];
                    end
                    next_arb = cyc + (mwe ? 2 : 3);
                    last_a   = !mw_b;
                end
            end
        end
    end

    // ---------------- per-cycle compare and invariants ----------------
    bit pend_q [$];   // requester of each read grant awaiting its rvalid (1 = b)
    initial begin
        bit who;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("gnt_a",       bus.gnt_a,       cur.ga);
                check("gnt_b",       bus.gnt_b,       cur.gb);
                check("gpr_wr",      bus.gpr_wr,      cur.wr);
                check("gpr_rd",      bus.gpr_rd,      cur.rd);
                check("busy",        bus.busy,        cur.busy);
                check("rvalid_a",    bus.rvalid_a,    cur.rva);
                check("rvalid_b",    bus.rvalid_b,    cur.rvb);
                check("gpr_addr",    bus.gpr_addr,    e_addr);
                check("gpr_data_in", bus.gpr_data_in, e_din);
                check("rdata",       bus.rdata,       e_rdata);
                check("rd_and_wr",   bus.gpr_rd & bus.gpr_wr, 1'b0);
                check("gnt_both",    bus.gnt_a & bus.gnt_b, 1'b0);
                check("rvalid_both", bus.rvalid_a & bus.rvalid_b, 1'b0);
                if (!rst_n) pend_q.delete();
                if (bus.rvalid_a || bus.rvalid_b) begin
                    if (pend_q.size() == 0) begin
                        check("rvalid_without_gnt", 1, 0);
                    end else begin
                        who = pend_q.pop_front();
                        check("rvalid_owner", bus.rvalid_b, who);
                    end
                end
                if (bus.gpr_rd && bus.gnt_a) pend_q.push_back(1'b0);
                if (bus.gpr_rd && bus.gnt_b) pend_q.push_back(1'b1);
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit exp_order [4];
        bit got_order [$];
        int guard;

        bus.req_a = 0; bus.we_a = 0; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 0; bus.we_b = 0; bus.addr_b = '0; bus.wdata_b = '0;

        #1 rst_n = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();
        check("reset_busy",     bus.busy,     1'b0);
        check("reset_gpr_addr", bus.gpr_addr, 12'h000);
        check("reset_rdata",    bus.rdata,    14'h0000);
        rst_n = 1'b1;
        tick();

        // Write from a.
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 12'h005; bus.wdata_a = 14'h1ABC;
        tick();
        check("wr_gnt_a",       bus.gnt_a,       1'b1);
        check("wr_gpr_wr",      bus.gpr_wr,      1'b1);
        check("wr_gpr_addr",    bus.gpr_addr,    12'h005);
        check("wr_gpr_data_in", bus.gpr_data_in, 14'h1ABC);
        bus.req_a = 0;
        tick();
        check("wr_busy_t2",     bus.busy,        1'b0);

        // Read from b of a GPR word holding 14'h0123.
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 12'h0AA;
        tick();
        check("rd_gnt_b",    bus.gnt_b,    1'b1);
        check("rd_gpr_rd",   bus.gpr_rd,   1'b1);
        check("rd_rvalid_a", bus.rvalid_a, 1'b0);
        bus.req_b = 0;
        tick();
        check("rd_rvalid_b",  bus.rvalid_b, 1'b1);
        check("rd_rdata",     bus.rdata,    14'h0123);
        check("rd_rvalid_a2", bus.rvalid_a, 1'b0);
        tick();

        // Late request: b rises during a's ISSUE cycle; a's inputs change too.
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 12'h03C;
        tick();
        check("late_gnt_a", bus.gnt_a, 1'b1);
        bus.req_a = 0; bus.addr_a = 12'h7FF;
        bus.req_b = 1; bus.we_b = 1; bus.addr_b = 12'h044; bus.wdata_b = 14'h0F0F;
        #1 check("late_addr_issue", bus.gpr_addr, 12'h03C);
        tick();
        check("late_gnt_b_resp", bus.gnt_b,    1'b0);
        check("late_addr_resp",  bus.gpr_addr, 12'h03C);
        tick();
        check("late_gnt_b_idle", bus.gnt_b, 1'b0);
        tick();
        check("late_gnt_b",      bus.gnt_b,    1'b1);
        check("late_addr_b",     bus.gpr_addr, 12'h044);
        bus.req_b = 0;
        tick();

        // Reset during ISSUE of a read.
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 12'h010;
        tick();
        check("rst_pre_gpr_rd", bus.gpr_rd, 1'b1);
        rst_n = 1'b0;
        bus.req_a = 0;
        #1;
        check("rst_gpr_rd", bus.gpr_rd, 1'b0);
        check("rst_busy",   bus.busy,   1'b0);
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("rst_no_rvalid", bus.rvalid_a | bus.rvalid_b, 1'b0);
        end

        // Contention: both held high for four write accesses.
`ifdef GPR_ARB_ROUND_ROBIN_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 12'($urandom_range(0, 15)); bus.wdata_a = 14'($urandom);
        bus.req_b = 1; bus.we_b = 1; bus.addr_b = 12'($urandom_range(0, 15)); bus.wdata_b = 14'($urandom);
        guard = 0;
        while (got_order.size() < 4 && guard < 40) begin
            tick();
            guard++;
            if (bus.gnt_a) begin
                got_order.push_back(1'b0);
                bus.addr_a = 12'($urandom_range(0, 15)); bus.wdata_a = 14'($urandom);
            end
            if (bus.gnt_b) begin
                got_order.push_back(1'b1);
                bus.addr_b = 12'($urandom_range(0, 15)); bus.wdata_b = 14'($urandom);
            end
        end
        bus.req_a = 0; bus.req_b = 0;
        check("contention_grants", got_order.size(), 4);
        for (int i = 0; i < 4 && i < got_order.size(); i++)
            check($sformatf("contention_winner_%0d", i), got_order[i], exp_order[i]);
        repeat (4) tick();

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (bus.req_a && bus.gnt_a) begin
                bus.req_a = 1'($urandom_range(0, 1));
                bus.we_a = 1'($urandom); bus.addr_a = 12'($urandom_range(0, 15)); bus.wdata_a = 14'($urandom);
            end else if (!bus.req_a && $urandom_range(0, 3) == 0) begin
                bus.req_a = 1;
                bus.we_a = 1'($urandom); bus.addr_a = 12'($urandom_range(0, 15)); bus.wdata_a = 14'($urandom);
            end
            if (bus.req_b && bus.gnt_b) begin
                bus.req_b = 1'($urandom_range(0, 1));
                bus.we_b = 1'($urandom); bus.addr_b = 12'($urandom_range(0, 15)); bus.wdata_b = 14'($urandom);
            end else if (!bus.req_b && $urandom_range(0, 3) == 0) begin
                bus.req_b = 1;
                bus.we_b = 1'($urandom); bus.addr_b = 12'($urandom_range(0, 15)); bus.wdata_b = 14'($urandom);
            end
        end
        bus.req_a = 0; bus.req_b = 0;
        repeat (6) tick();
        check("reads_all_answered", pend_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
